// File: rtl/hyp_dispatch_pkg.sv
// Shared widths and FSM state encoding for the hypotenuse job dispatcher.
package hyp_dispatch_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 9;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_CLR  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hyp_sync_fifo.sv
// Synchronous FIFO with a combinational head output. Full and empty are
// distinguished by an extra wrap bit on each pointer.
module hyp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hyp_job_dispatch.sv
// Buffers operand pairs, issues them one at a time to the hypotenuse unit,
// and queues the results, with a per-job watchdog and completion counter.
module hyp_job_dispatch
    import hyp_dispatch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  in_a_bi,
    input  logic [OP_W-1:0]  in_b_bi,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RES_W-1:0] out_c_bo,
    output logic             hyp_start_o,
    output logic [OP_W-1:0]  hyp_a_bo,
    output logic [OP_W-1:0]  hyp_b_bo,
    input  logic [RES_W-1:0] hyp_c_bi,
    input  logic             hyp_ready_i,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    wait_nxt;
    logic                waiting;
    logic                tmo_hit;
    logic                in_full;
    logic                in_empty;
    logic                out_full;
    logic                out_empty;
    logic                in_push;
    logic                in_pop;
    logic                out_push;
    logic                out_pop;
    logic [2*OP_W-1:0]   in_head;

    assign in_ready_o  = !in_full;
    assign out_valid_o = !out_empty;
    assign in_push     = in_valid_i && !in_full;
    assign out_pop     = !out_empty && out_ready_i;

    // Output space is checked at issue time; nothing else pushes the output FIFO.
    assign in_pop   = (state == IDLE) && !in_empty && !out_full;
    assign waiting  = (state == WAIT_CLR) || (state == WAIT_DONE);
    assign wait_nxt = wait_cnt + CNT_ONE;
    assign tmo_hit  = waiting && (wait_nxt == TMO_LIM);
    assign out_push = (state == WAIT_DONE) && hyp_ready_i && !tmo_hit;

    assign busy_o = (state != IDLE) || !in_empty || !out_empty;

    hyp_sync_fifo #(.WIDTH(2*OP_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (in_push),
        .pop     (in_pop),
        .wdata   ({in_a_bi, in_b_bi}),
        .rdata   (in_head),
        .full    (in_full),
        .empty   (in_empty)
    );

    hyp_sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (out_push),
        .pop     (out_pop),
        .wdata   (hyp_c_bi),
        .rdata   (out_c_bo),
        .full    (out_full),
        .empty   (out_empty)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            hyp_start_o <= 1'b0;
            hyp_a_bo    <= '0;
            hyp_b_bo    <= '0;
            wait_cnt    <= '0;
            timeout_o   <= 1'b0;
            done_cnt_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_pop) begin
                        hyp_a_bo    <= in_head[2*OP_W-1 -: OP_W];
                        hyp_b_bo    <= in_head[OP_W-1:0];
                        hyp_start_o <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    hyp_start_o <= 1'b0;
                    state       <= WAIT_CLR;
                end
                // Ready is sticky from the previous job; wait for the unit to drop it.
                WAIT_CLR: begin
                    wait_cnt <= wait_nxt;
                    if (tmo_hit) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else if (!hyp_ready_i) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_nxt;
                    if (tmo_hit) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else if (hyp_ready_i) begin
                        done_cnt_o <= done_cnt_o + CNT_ONE;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyp_job_dispatch.sv
// Scoreboard bench for hyp_job_dispatch driving a behavioural hypotenuse unit.
module tb_hyp_job_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_a_bi = '0;
    logic [7:0] in_b_bi = '0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [8:0] out_c_bo;
    logic       hyp_start_o;
    logic [7:0] hyp_a_bo;
    logic [7:0] hyp_b_bo;
    logic [8:0] hyp_c_bi = '0;
    logic       hyp_ready_i = 1'b0;
    logic       busy_o;
    logic       timeout_o;
    logic [15:0] done_cnt_o;

    always #5 clk_i = ~clk_i;

    hyp_job_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_bi     (in_a_bi),
        .in_b_bi     (in_b_bi),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_c_bo    (out_c_bo),
        .hyp_start_o (hyp_start_o),
        .hyp_a_bo    (hyp_a_bo),
        .hyp_b_bo    (hyp_b_bo),
        .hyp_c_bi    (hyp_c_bi),
        .hyp_ready_i (hyp_ready_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .done_cnt_o  (done_cnt_o)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    // Burst and back-pressure vectors with hand-computed hypotenuses.
    int burst_a[4] = '{5, 0, 255, 8};
    int burst_b[4] = '{12, 0, 255, 15};
    int burst_c[4] = '{13, 0, 360, 17};
    int bp_a[9] = '{3, 6, 5, 8, 7, 20, 12, 9, 15};
    int bp_b[9] = '{4, 8, 12, 15, 24, 21, 16, 12, 20};
    int bp_c[9] = '{5, 10, 13, 17, 25, 29, 20, 15, 25};

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Behavioural unit: sticky ready, optional stale hold and hang, no reset.
    int   u_lat = 3;
    bit   u_hang = 1'b0;
    int   u_stale = 0;
    bit   u_busy = 1'b0;
    int   u_cnt = 0;
    int   u_hold = 0;
    int   u_a = 0;
    int   u_b = 0;

    always @(negedge clk_i) begin
        if (hyp_start_o) begin
            u_a    = int'(hyp_a_bo);
            u_b    = int'(hyp_b_bo);
            u_busy = 1'b1;
            u_cnt  = u_lat;
            u_hold = u_stale;
            if (u_hold == 0) hyp_ready_i = 1'b0;
        end else if (u_busy) begin
            if (u_hold > 0) begin
                u_hold--;
                if (u_hold == 0) hyp_ready_i = 1'b0;
            end else if (!u_hang) begin
                if (u_cnt > 0) u_cnt--;
                else begin
                    hyp_c_bi    = 9'(isqrt(u_a * u_a + u_b * u_b));
                    hyp_ready_i = 1'b1;
                    u_busy      = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out_extra: got %0d, expected no output", out_c_bo);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_c", int'(out_c_bo), int'(mon_e));
            end
        end
    end

    int start_run = 0;
    int start_total = 0;

    always @(negedge clk_i) begin
        if (hyp_start_o) begin
            if (start_run == 0) start_total++;
            start_run++;
        end else if (start_run > 0) begin
            check("start_width", start_run, 1);
            start_run = 0;
        end
    end

    task automatic push_pair(input int a, input int b, input int c, input bit track);
        int t = 0;
        in_a_bi    = 8'(a);
        in_b_bi    = 8'(b);
        in_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            t++;
            if (t > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL push_timeout: got in_ready 0, expected 1 within 500 cycles");
                in_valid_i = 1'b0;
                return;
            end
        end
        if (track) exp_q.push_back(9'(c));
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_start(output bit seen);
        int t = 0;
        seen = 1'b0;
        while (t < 200) begin
            @(negedge clk_i);
            if (hyp_start_o) begin
                seen = 1'b1;
                break;
            end
            t++;
        end
        check("start_seen", int'(seen), 1);
    endtask

    int  base_done;
    int  base_start;
    int  n_pushed;
    int  tmo_n;
    int  t_wait;
    bit  seen;

    initial begin
        wait_cycles(3);
        check("rst_in_ready", int'(in_ready_o), 1);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_start", int'(hyp_start_o), 0);
        check("rst_a", int'(hyp_a_bo), 0);
        check("rst_b", int'(hyp_b_bo), 0);
        check("rst_timeout", int'(timeout_o), 0);
        check("rst_done", int'(done_cnt_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst_n_i = 1'b1;
        wait_cycles(2);

        // Single job
        out_ready_i = 1'b1;
        push_pair(3, 4, 5, 1'b1);
        wait_drain();
        wait_cycles(5);
        check("single_done", int'(done_cnt_o), 1);
        check("single_busy", int'(busy_o), 0);

        // Burst
        for (int i = 0; i < 4; i++) push_pair(burst_a[i], burst_b[i], burst_c[i], 1'b1);
        wait_drain();
        wait_cycles(5);
        check("burst_done", int'(done_cnt_o), 5);

        // Back-pressure
        out_ready_i = 1'b0;
        base_start  = start_total;
        base_done   = int'(done_cnt_o);
        n_pushed    = 0;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    push_pair(bp_a[i], bp_b[i], bp_c[i], 1'b1);
                    n_pushed++;
                end
            end
        join_none
        wait_cycles(80);
        check("bp_in_ready", int'(in_ready_o), 0);
        check("bp_pushed", n_pushed, 8);
        check("bp_starts", start_total - base_start, 4);
        check("bp_done", int'(done_cnt_o) - base_done, 4);
        check("bp_out_valid", int'(out_valid_o), 1);
        out_ready_i = 1'b1;
        t_wait = 0;
        while (n_pushed < 9 && t_wait < 1000) begin
            @(posedge clk_i);
            t_wait++;
        end
        #1;
        check("bp_all_pushed", n_pushed, 9);
        wait_drain();
        wait_cycles(5);
        check("bp_done_all", int'(done_cnt_o), 14);

        // Stale ready held across the start strobe
        base_done = int'(done_cnt_o);
        u_stale   = 2;
        push_pair(20, 21, 29, 1'b1);
        wait_start(seen);
        wait_cycles(2);
        check("stale_no_done", int'(done_cnt_o), base_done);
        check("stale_no_out", int'(out_valid_o), 0);
        u_stale = 0;
        wait_drain();
        wait_cycles(5);
        check("stale_done", int'(done_cnt_o), base_done + 1);

        // Watchdog
        base_done = int'(done_cnt_o);
        u_hang    = 1'b1;
        push_pair(1, 1, 0, 1'b0);
        wait_start(seen);
        tmo_n = 0;
        while (tmo_n < 100) begin
            @(negedge clk_i);
            tmo_n++;
            if (timeout_o) break;
        end
        check("tmo_cycles", tmo_n, TIMEOUT + 1);
        check("tmo_no_done", int'(done_cnt_o), base_done);
        check("tmo_no_out", int'(out_valid_o), 0);
        check("tmo_idle", int'(busy_o), 0);
        u_hang = 1'b0;
        wait_cycles(1);
        push_pair(6, 8, 10, 1'b1);
        wait_drain();
        wait_cycles(5);
        check("tmo_next_done", int'(done_cnt_o), base_done + 1);
        check("tmo_sticky", int'(timeout_o), 1);

        // Asynchronous reset during WAIT_DONE
        u_lat = 15;
        push_pair(9, 12, 15, 1'b0);
        wait_start(seen);
        repeat (5) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_start", int'(hyp_start_o), 0);
        check("arst_a", int'(hyp_a_bo), 0);
        check("arst_b", int'(hyp_b_bo), 0);
        check("arst_done", int'(done_cnt_o), 0);
        check("arst_timeout", int'(timeout_o), 0);
        check("arst_out_valid", int'(out_valid_o), 0);
        check("arst_in_ready", int'(in_ready_o), 1);
        check("arst_busy", int'(busy_o), 0);
        wait_cycles(2);
        rst_n_i = 1'b1;
        t_wait = 0;
        while (!hyp_ready_i && t_wait < 100) begin
            @(posedge clk_i);
            t_wait++;
        end
        check("arst_unit_ready", int'(hyp_ready_i), 1);
        wait_cycles(5);
        check("arst_late_out", int'(out_valid_o), 0);
        check("arst_late_done", int'(done_cnt_o), 0);
        check("arst_late_busy", int'(busy_o), 0);

        check("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
